// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving a registered mux select, one-hot grant and valid/ready handshake.
// Optional feature: define RR_ARB_LOCK_EN to add the 'lock' input that re-grants the current winner.
module rr_select_arbiter #(
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEPTH-1:0]     req,
  output logic [SEL_WIDTH-1:0] select,
  output logic [DEPTH-1:0]     grant,
  output logic                 selValid,
  input  logic                 selReady
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic                 lock
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] select_q, select_d;
  logic [DEPTH-1:0]     grant_q, grant_d;

  logic                 transfer_s;
  logic                 lock_hold_s;
  logic [SEL_WIDTH-1:0] next_ptr_s;
  logic [SEL_WIDTH-1:0] base_s;
  logic [SEL_WIDTH:0]   pick_s;

  // Increment with explicit wrap so non-power-of-two DEPTH never yields an index >= DEPTH.
  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] v);
    logic [SEL_WIDTH-1:0] r;
    if (int'(v) >= DEPTH - 1) begin
      r = '0;
    end else begin
      r = v + SEL_WIDTH'(1);
    end
    return r;
  endfunction

  // Returns {found, index} of the first set request searching from base upwards with wrap.
  function automatic logic [SEL_WIDTH:0] rr_pick(input logic [DEPTH-1:0]     r,
                                                 input logic [SEL_WIDTH-1:0] base);
    logic                 found;
    logic [SEL_WIDTH-1:0] win;
    int                   idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(base) + k;
      if (idx >= DEPTH) begin
        idx = idx - DEPTH;
      end
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = SEL_WIDTH'(idx);
      end
    end
    return {found, win};
  endfunction

  // Next-state, pointer and grant computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    select_d    = select_q;
    grant_d     = grant_q;
    lock_hold_s = 1'b0;
    transfer_s  = (state_q == GRANT) && selReady;
    next_ptr_s  = wrap_inc(select_q);
`ifdef RR_ARB_LOCK_EN
    lock_hold_s = transfer_s && lock && req[select_q];
`endif
    // In GRANT the only re-arbitration happens on transfer, which uses the advanced pointer.
    base_s = (state_q == GRANT) ? next_ptr_s : ptr_q;
    pick_s = rr_pick(req, base_s);

    case (state_q)
      IDLE: begin
        if (pick_s[SEL_WIDTH]) begin
          state_d  = GRANT;
          select_d = pick_s[SEL_WIDTH-1:0];
          grant_d  = {{(DEPTH-1){1'b0}}, 1'b1} << pick_s[SEL_WIDTH-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (lock_hold_s) begin
          state_d = GRANT;
        end else if (transfer_s) begin
          ptr_d = next_ptr_s;
          if (pick_s[SEL_WIDTH]) begin
            state_d  = GRANT;
            select_d = pick_s[SEL_WIDTH-1:0];
            grant_d  = {{(DEPTH-1){1'b0}}, 1'b1} << pick_s[SEL_WIDTH-1:0];
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      select_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      grant_q  <= grant_d;
    end
  end

  assign select   = select_q;
  assign grant    = grant_q;
  assign selValid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed self-checking bench for rr_select_arbiter (DEPTH=8 and DEPTH=5 instances).
module tb_rr_select_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [2:0] select;
  logic [7:0] grant;
  logic       selValid;
  logic       selReady;
  logic [4:0] req5;
  logic [2:0] select5;
  logic [4:0] grant5;
  logic       selValid5;
  logic       selReady5;
`ifdef RR_ARB_LOCK_EN
  logic       lock;
  logic       lock5;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  rr_select_arbiter #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .select(select), .grant(grant),
    .selValid(selValid), .selReady(selReady)
`ifdef RR_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  rr_select_arbiter #(.DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .select(select5), .grant(grant5),
    .selValid(selValid5), .selReady(selReady5)
`ifdef RR_ARB_LOCK_EN
    , .lock(lock5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; selReady = 1'b0; req5 = 5'b00000; selReady5 = 1'b0;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b0; lock5 = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", {31'd0, selValid}, 32'd0);
    chk("reset_select", {29'd0, select}, 32'd0);
    chk("reset_grant", {24'd0, grant}, 32'd0);
    rst = 1'b0;

    // Single request, one-cycle latency, then back to IDLE with ptr=3
    req = 8'h04; selReady = 1'b1;
    step();
    chk("single_valid", {31'd0, selValid}, 32'd1);
    chk("single_select", {29'd0, select}, 32'd2);
    chk("single_grant", {24'd0, grant}, 32'h04);
    req = 8'h00;
    step();
    chk("idle_valid", {31'd0, selValid}, 32'd0);
    chk("idle_hold_select", {29'd0, select}, 32'd2);
    chk("idle_hold_grant", {24'd0, grant}, 32'h04);
    req = 8'h0C;
    step();
    chk("ptr3_select", {29'd0, select}, 32'd3);
    req = 8'h00;
    step();
    chk("ptr3_idle", {31'd0, selValid}, 32'd0);

    // All requesting, continuous ready: 0..7,0 with no bubbles
    do_reset();
    req = 8'hFF; selReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_select_%0d", i), {29'd0, select}, 32'(i % 8));
      chk($sformatf("rr_valid_%0d", i), {31'd0, selValid}, 32'd1);
    end

    // Hold under backpressure despite request changes
    do_reset();
    req = 8'h20; selReady = 1'b0;
    step();
    chk("hold_first_select", {29'd0, select}, 32'd5);
    req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold_select_%0d", i), {29'd0, select}, 32'd5);
      chk($sformatf("hold_grant_%0d", i), {24'd0, grant}, 32'h20);
      chk($sformatf("hold_valid_%0d", i), {31'd0, selValid}, 32'd1);
    end
    selReady = 1'b1;
    step();
    chk("hold_release_select", {29'd0, select}, 32'd0);
    chk("hold_release_grant", {24'd0, grant}, 32'h01);

    // DEPTH=5 wrap: reach ptr=4 via a grant of index 3
    do_reset();
    req = 8'h00; selReady = 1'b0;
    req5 = 5'b01000; selReady5 = 1'b1;
    step();
    chk("d5_setup_select", {29'd0, select5}, 32'd3);
    req5 = 5'b10001;
    step();
    chk("d5_select_a", {29'd0, select5}, 32'd4);
    chk("d5_grant_a", {27'd0, grant5}, 32'h10);
    step();
    chk("d5_select_wrap", {29'd0, select5}, 32'd0);
    chk("d5_grant_wrap", {27'd0, grant5}, 32'h01);
    step();
    chk("d5_select_b", {29'd0, select5}, 32'd4);
    req5 = 5'b00000; selReady5 = 1'b0;

    // Asynchronous reset mid-GRANT
    do_reset();
    req = 8'h08; selReady = 1'b0;
    step();
    chk("arst_pre_select", {29'd0, select}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, selValid}, 32'd0);
    chk("arst_select", {29'd0, select}, 32'd0);
    chk("arst_grant", {24'd0, grant}, 32'd0);
    req = 8'h88;
    step();
    chk("arst_held_valid", {31'd0, selValid}, 32'd0);
    #2;
    rst = 1'b0;
    step();
    chk("arst_after_select", {29'd0, select}, 32'd3);
    chk("arst_after_grant", {24'd0, grant}, 32'h08);

    // IDLE ignores selReady; empty request keeps IDLE
    do_reset();
    req = 8'h00; selReady = 1'b1;
    step();
    step();
    chk("idle_ready_valid", {31'd0, selValid}, 32'd0);
    chk("idle_ready_select", {29'd0, select}, 32'd0);

`ifdef RR_ARB_LOCK_EN
    // Lock re-grants the current winner
    do_reset();
    req = 8'h06; selReady = 1'b1; lock = 1'b1;
    step();
    chk("lock_first", {29'd0, select}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("lock_hold_%0d", i), {29'd0, select}, 32'd1);
    end
    lock = 1'b0;
    step();
    chk("lock_release", {29'd0, select}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_select_arbiter.md
RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of requesters, equal to the downstream mux input count; legal range 2..256.
REQ-002 SHALL have parameter SEL_WIDTH, default log2(DEPTH) rounded up: width of the select output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port req, input, DEPTH bits: request vector; bit i = requester i wants the mux.
REQ-006 SHALL have port select, output, SEL_WIDTH bits: registered index of the granted requester; drives the mux select input.
REQ-007 SHALL have port grant, output, DEPTH bits: registered one-hot grant; bit select set, all others zero.
REQ-008 SHALL have port selValid, output, 1 bit: select/grant hold a valid grant.
REQ-009 SHALL have port selReady, input, 1 bit: consumer accepts the current grant.

Function
REQ-010 SHALL implement two states: IDLE (selValid=0) and GRANT (selValid=1).
REQ-011 SHALL keep an internal pointer ptr (0..DEPTH-1): the highest-priority index for the next arbitration.
REQ-012 SHALL arbitrate as follows: winner = first index i with req[i]=1, searching ptr, ptr+1, ..., DEPTH-1, 0, ..., ptr-1.
REQ-013 IDLE: if req != 0 at a rising edge, SHALL register the winner into select/grant and enter GRANT; latency req-to-selValid = 1 cycle.
REQ-014 IDLE with req == 0 SHALL remain IDLE, with select/grant holding their last values and selValid=0.
REQ-015 GRANT with selReady=0 SHALL hold select, grant, and ptr unchanged, regardless of req changes, including deassertion of the granted bit.
REQ-016 Transfer occurs when selValid=1 and selReady=1 at a rising edge; on transfer, ptr SHALL become select+1, wrapping DEPTH-1 to 0 (also for non-power-of-two DEPTH).
REQ-017 On transfer, the block SHALL re-arbitrate in the same edge using the updated ptr and current req: if any bit is set, stay in GRANT with the new winner (back-to-back, no bubble); else go to IDLE.
REQ-018 selReady while in IDLE SHALL be ignored.
REQ-019 select SHALL never hold a value >= DEPTH.
REQ-020 grant SHALL always be the one-hot decode of select, or all zero after reset before the first grant.

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force state=IDLE, ptr=0, select=0, grant=0, selValid=0.
REQ-022 Reset mid-GRANT SHALL drop the pending grant without transfer; after release, the first arbitration starts from ptr=0.
REQ-023 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge at which rst=0.

Configuration
REQ-024 Macro RR_ARB_LOCK_EN, when defined, SHALL add input port lock (1 bit, listed after selReady).
REQ-025 With RR_ARB_LOCK_EN defined: on a transfer with lock=1 and req[select]=1, the block SHALL re-grant the same index and leave ptr unchanged. If lock=1 but req[select]=0, normal REQ-016/017 behaviour SHALL apply.
REQ-026 With RR_ARB_LOCK_EN undefined: port lock SHALL be absent, and behaviour SHALL be exactly REQ-010..REQ-020.

Verification (DEPTH=8 unless stated)
REQ-027 After reset, req=8'b0000_0100 for 1 cycle with selReady=1 -> selValid=1 one cycle later, select=2, grant=8'h04; next edge -> IDLE, ptr=3.
REQ-028 req=8'hFF held, selReady=1 continuously -> select sequence 0,1,2,...,7,0, with selValid constantly 1 (no bubbles).
REQ-029 Grant select=5, selReady=0 for 4 cycles while req changes to 8'h01 -> select=5 and grant=8'h20 stable throughout; on selReady=1 -> select=0.
REQ-030 DEPTH=5, req=5'b10001, ptr=4, selReady=1 -> select=4, then 0 (wrap), then 4.
REQ-031 Assert rst asynchronously mid-cycle during GRANT (select=3) -> selValid, select, and grant go to 0 before the next clock edge; after release with req=8'h88 -> select=3.
REQ-032 With RR_ARB_LOCK_EN defined: req=8'h06, lock=1, selReady=1 -> select stays 1 for every transfer; lock=0 -> next select=2.
